// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: state encoding,
// opcodes, ALU operation codes, datapath select codes and per-state outputs.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECR    = 4'd7,
    EXECI    = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       regWrite;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrl_t;

  // Moore outputs of each state; the branch-taken PC enable is added outside.
  function automatic ctrl_t stateOutputs(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irWrite   = 1'b1;
        c.pcWrite   = 1'b1;
        c.aluSrcA   = SRCA_PC;
        c.aluSrcB   = SRCB_FOUR;
        c.resultSrc = RES_ALURESULT;
      end
      DECODE: begin
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_IMM;
      end
      MEMADR: begin
        c.aluSrcA = SRCA_A;
        c.aluSrcB = SRCB_IMM;
      end
      MEMREAD:  c.adrSrc = 1'b1;
      MEMWB: begin
        c.resultSrc = RES_DATA;
        c.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECR: begin
        c.aluSrcA = SRCA_A;
        c.aluSrcB = SRCB_RS2;
        c.aluOp   = ALUOP_FUNCT;
      end
      EXECI: begin
        c.aluSrcA = SRCA_A;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALUOP_FUNCT;
      end
      ALUWB:    c.regWrite = 1'b1;
      BRANCH: begin
        c.aluSrcA = SRCA_A;
        c.aluSrcB = SRCB_RS2;
        c.aluOp   = ALUOP_SUB;
      end
      JAL: begin
        c.pcWrite = 1'b1;
        c.aluSrcA = SRCA_OLDPC;
        c.aluSrcB = SRCB_FOUR;
      end
      TRAP:     c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALUop plus the instruction's
// funct fields into the 4-bit ALU operation code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       opb5_i,
  output logic [3:0] aluControl_o
);

  // Subtract only for R-type funct3=000 with funct7[5]; addi ignores bit 30.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALU_ADD;
      ALUOP_SUB: aluControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  aluControl_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl_o = ALU_SLL;
          3'b010:  aluControl_o = ALU_SLT;
          3'b011:  aluControl_o = ALU_SLTU;
          3'b100:  aluControl_o = ALU_XOR;
          3'b101:  aluControl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  aluControl_o = ALU_OR;
          default: aluControl_o = ALU_AND;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM with registered datapath
// controls, sticky trap on unsupported opcodes or branch funct3.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 zero1,
  output logic                 PCwrite,
  output logic                 Adrsrc,
  output logic                 Memwrite,
  output logic                 IRwrite,
  output logic [1:0]           ALUsrcA,
  output logic [1:0]           ALUsrcB,
  output logic [1:0]           Resultsrc,
  output logic [1:0]           immsrc,
  output logic                 Regwrite,
  output logic [ALUCTRL_W-1:0] ALUcontrol,
  output logic                 illegal,
  output logic [3:0]           state_dbg
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branchValid;
  logic       branchTake;
  logic [3:0] aluCtrl;
  logic       unusedInstrBits;

  assign opcode          = instr[6:0];
  assign funct3          = instr[14:12];
  assign branchValid     = (funct3[2:1] == 2'b00);
  assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = FETCH;
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_IMM:            state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = branchValid ? FETCH : TRAP;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  // Outputs are precomputed for the state being entered so they change with the state register.
  assign ctrl_d = stateOutputs(state_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign branchTake = (state_q == BRANCH) && branchValid && (zero1 ^ funct3[0]);

  always_comb begin
    case (opcode)
      OP_STORE:  immsrc = IMM_S;
      OP_BRANCH: immsrc = IMM_B;
      OP_JAL:    immsrc = IMM_J;
      default:   immsrc = IMM_I;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .aluOp_i      (ctrl_q.aluOp),
    .funct3_i     (funct3),
    .funct7b5_i   (instr[30]),
    .opb5_i       (opcode[5]),
    .aluControl_o (aluCtrl)
  );

  assign PCwrite    = ctrl_q.pcWrite | branchTake;
  assign Adrsrc     = ctrl_q.adrSrc;
  assign Memwrite   = ctrl_q.memWrite;
  assign IRwrite    = ctrl_q.irWrite;
  assign ALUsrcA    = ctrl_q.aluSrcA;
  assign ALUsrcB    = ctrl_q.aluSrcB;
  assign Resultsrc  = ctrl_q.resultSrc;
  assign Regwrite   = ctrl_q.regWrite;
  assign ALUcontrol = aluCtrl;
  assign illegal    = ctrl_q.illegal;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed, table-driven bench for mc_control_unit with hand-written
// sequences for asynchronous reset, trap stickiness and bad branch funct3.
module tb_mc_control_unit;

  localparam logic [3:0] ST_RESET    = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEMADR   = 4'd3;
  localparam logic [3:0] ST_MEMREAD  = 4'd4;
  localparam logic [3:0] ST_MEMWB    = 4'd5;
  localparam logic [3:0] ST_MEMWRITE = 4'd6;
  localparam logic [3:0] ST_EXECR    = 4'd7;
  localparam logic [3:0] ST_EXECI    = 4'd8;
  localparam logic [3:0] ST_ALUWB    = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JAL      = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;

  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BNE  = 32'h00001463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_BBAD = 32'h00002463;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero1;
  logic        PCwrite, Adrsrc, Memwrite, IRwrite, Regwrite, illegal;
  logic [1:0]  ALUsrcA, ALUsrcB, Resultsrc, immsrc;
  logic [3:0]  ALUcontrol;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero1;
    logic [3:0]  st;
    logic [17:0] outs;
  } vec_t;

  vec_t vecs[$];

  mc_control_unit #(.ALUCTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero1      (zero1),
    .PCwrite    (PCwrite),
    .Adrsrc     (Adrsrc),
    .Memwrite   (Memwrite),
    .IRwrite    (IRwrite),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .Resultsrc  (Resultsrc),
    .immsrc     (immsrc),
    .Regwrite   (Regwrite),
    .ALUcontrol (ALUcontrol),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs expected outputs in the same order checkOutput samples them.
  function automatic logic [17:0] outs(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [1:0] imm,
                                       input logic regw, input logic [3:0] aluc, input logic ill);
    return {pcw, adr, memw, irw, a, b, res, imm, regw, aluc, ill};
  endfunction

  task automatic addRow(input string name, input logic [31:0] i, input logic z,
                        input logic [3:0] st, input logic [17:0] o);
    vec_t v;
    v.name  = name;
    v.instr = i;
    v.zero1 = z;
    v.st    = st;
    v.outs  = o;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic z);
    instr = i;
    zero1 = z;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expState, input logic [17:0] expOuts);
    logic [21:0] act;
    logic [21:0] expv;
    act  = {state_dbg, PCwrite, Adrsrc, Memwrite, IRwrite, ALUsrcA, ALUsrcB,
            Resultsrc, immsrc, Regwrite, ALUcontrol, illegal};
    expv = {expState, expOuts};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (state|pcw adr memw irw A B res imm regw aluc ill)",
               name, act, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    zero1 = 1'b0;

    // lw: 5 cycles, register write only in MEMWB from memory data
    addRow("lw fetch",   I_LW, 1'b0, ST_FETCH,   outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("lw decode",  I_LW, 1'b1, ST_DECODE,  outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("lw memadr",  I_LW, 1'b0, ST_MEMADR,  outs(0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("lw memread", I_LW, 1'b1, ST_MEMREAD, outs(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,0));
    addRow("lw memwb",   I_LW, 1'b0, ST_MEMWB,   outs(0,0,0,0,2'b00,2'b00,2'b01,2'b00,1,4'b0000,0));
    // sw: 4 cycles, S immediate
    addRow("sw fetch",    I_SW, 1'b0, ST_FETCH,    outs(1,0,0,1,2'b00,2'b10,2'b10,2'b01,0,4'b0000,0));
    addRow("sw decode",   I_SW, 1'b0, ST_DECODE,   outs(0,0,0,0,2'b01,2'b01,2'b00,2'b01,0,4'b0000,0));
    addRow("sw memadr",   I_SW, 1'b1, ST_MEMADR,   outs(0,0,0,0,2'b10,2'b01,2'b00,2'b01,0,4'b0000,0));
    addRow("sw memwrite", I_SW, 1'b0, ST_MEMWRITE, outs(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,4'b0000,0));
    // R-type add, sub, xor
    addRow("add fetch",  I_ADD, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("add decode", I_ADD, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("add execr",  I_ADD, 1'b0, ST_EXECR,  outs(0,0,0,0,2'b10,2'b00,2'b00,2'b00,0,4'b0000,0));
    addRow("add aluwb",  I_ADD, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'b0000,0));
    addRow("sub fetch",  I_SUB, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("sub decode", I_SUB, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("sub execr",  I_SUB, 1'b0, ST_EXECR,  outs(0,0,0,0,2'b10,2'b00,2'b00,2'b00,0,4'b0001,0));
    addRow("sub aluwb",  I_SUB, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'b0000,0));
    addRow("xor fetch",  I_XOR, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("xor decode", I_XOR, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("xor execr",  I_XOR, 1'b0, ST_EXECR,  outs(0,0,0,0,2'b10,2'b00,2'b00,2'b00,0,4'b0100,0));
    addRow("xor aluwb",  I_XOR, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'b0000,0));
    // I-type addi and srai
    addRow("addi fetch",  I_ADDI, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("addi decode", I_ADDI, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("addi execi",  I_ADDI, 1'b0, ST_EXECI,  outs(0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("addi aluwb",  I_ADDI, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'b0000,0));
    addRow("srai fetch",  I_SRAI, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));
    addRow("srai decode", I_SRAI, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    addRow("srai execi",  I_SRAI, 1'b0, ST_EXECI,  outs(0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,4'b1000,0));
    addRow("srai aluwb",  I_SRAI, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'b0000,0));
    // beq/bne with both zero1 values; 3 cycles each
    addRow("beq z1 fetch",  I_BEQ, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b10,0,4'b0000,0));
    addRow("beq z1 decode", I_BEQ, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b10,0,4'b0000,0));
    addRow("beq z1 branch", I_BEQ, 1'b1, ST_BRANCH, outs(1,0,0,0,2'b10,2'b00,2'b00,2'b10,0,4'b0001,0));
    addRow("beq z0 fetch",  I_BEQ, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b10,0,4'b0000,0));
    addRow("beq z0 decode", I_BEQ, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b10,0,4'b0000,0));
    addRow("beq z0 branch", I_BEQ, 1'b0, ST_BRANCH, outs(0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,4'b0001,0));
    addRow("bne z1 fetch",  I_BNE, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b10,0,4'b0000,0));
    addRow("bne z1 decode", I_BNE, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b10,0,4'b0000,0));
    addRow("bne z1 branch", I_BNE, 1'b1, ST_BRANCH, outs(0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,4'b0001,0));
    addRow("bne z0 fetch",  I_BNE, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b10,0,4'b0000,0));
    addRow("bne z0 decode", I_BNE, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b10,0,4'b0000,0));
    addRow("bne z0 branch", I_BNE, 1'b0, ST_BRANCH, outs(1,0,0,0,2'b10,2'b00,2'b00,2'b10,0,4'b0001,0));
    // jal: 4 cycles, J immediate, link write in ALUWB
    addRow("jal fetch",  I_JAL, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b11,0,4'b0000,0));
    addRow("jal decode", I_JAL, 1'b0, ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b11,0,4'b0000,0));
    addRow("jal jal",    I_JAL, 1'b0, ST_JAL,    outs(1,0,0,0,2'b01,2'b10,2'b00,2'b11,0,4'b0000,0));
    addRow("jal aluwb",  I_JAL, 1'b0, ST_ALUWB,  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,4'b0000,0));
    addRow("post fetch", I_ADD, 1'b0, ST_FETCH,  outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", ST_RESET, outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,0));
    reset = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].instr, vecs[k].zero1);
      checkOutput(vecs[k].name, vecs[k].st, vecs[k].outs);
    end

    // Asynchronous reset in the middle of EXECR aborts before any write.
    applyStimulus(I_ADD, 1'b0);
    applyStimulus(I_ADD, 1'b0);
    checkOutput("midreset execr", ST_EXECR, outs(0,0,0,0,2'b10,2'b00,2'b00,2'b00,0,4'b0000,0));
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset async", ST_RESET, outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,0));
    applyStimulus(I_ADD, 1'b0);
    checkOutput("midreset held", ST_RESET, outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,0));
    reset = 1'b0;
    applyStimulus(I_ADD, 1'b0);
    checkOutput("release fetch", ST_FETCH, outs(1,0,0,1,2'b00,2'b10,2'b10,2'b00,0,4'b0000,0));

    // Illegal opcode: sticky trap for 20 cycles, cleared only by reset.
    applyStimulus(32'h0, 1'b0);
    checkOutput("trap decode", ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,4'b0000,0));
    for (int c = 0; c < 20; c++) begin
      applyStimulus(32'h0, c[0]);
      checkOutput($sformatf("trap hold %0d", c), ST_TRAP,
                  outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,1));
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("trap cleared", ST_RESET, outs(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,4'b0000,0));
    applyStimulus(I_BBAD, 1'b0);
    reset = 1'b0;

    // Branch with funct3=010 does not update PC and traps.
    applyStimulus(I_BBAD, 1'b0);
    checkOutput("badbr fetch", ST_FETCH, outs(1,0,0,1,2'b00,2'b10,2'b10,2'b10,0,4'b0000,0));
    applyStimulus(I_BBAD, 1'b0);
    checkOutput("badbr decode", ST_DECODE, outs(0,0,0,0,2'b01,2'b01,2'b00,2'b10,0,4'b0000,0));
    applyStimulus(I_BBAD, 1'b1);
    checkOutput("badbr branch", ST_BRANCH, outs(0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,4'b0001,0));
    applyStimulus(I_BBAD, 1'b1);
    checkOutput("badbr trap", ST_TRAP, outs(0,0,0,0,2'b00,2'b00,2'b00,2'b10,0,4'b0000,1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle RV32I control unit that sequences the shared single-ALU/single-memory datapath (completehardware1). It decodes the IR contents, steps a Moore FSM through fetch/decode/execute/memory/writeback, and drives every datapath select and write-enable. It supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal. Any other opcode enters a sticky trap.

Parameters:
ALUCTRL_W, 4, width of ALUcontrol; fixed at 4 to match the ALU.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; forces S_RESET
instr  in  32  IR contents from the datapath; valid from DECODE onward
zero1  in  1  ALU zero flag, combinational from the datapath
PCwrite  out  1  PC register enable
Adrsrc  out  1  memory address: 0=PC, 1=result
Memwrite  out  1  memory write enable
IRwrite  out  1  IR/oldPC capture enable
ALUsrcA  out  2  00=PC, 01=oldPC, 10=A
ALUsrcB  out  2  00=WD(rs2), 01=immExt, 10=4
Resultsrc  out  2  00=ALUout, 01=data, 10=ALUresult
immsrc  out  2  00=I, 01=S, 10=B, 11=J
Regwrite  out  1  register file write enable
ALUcontrol  out  4  ALU operation
illegal  out  1  sticky trap indicator
state_dbg  out  4  current state encoding

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is high: state=S_RESET.
  - In S_RESET all outputs are 0: enables 0, selects 00, ALUcontrol=0000 (add), illegal=0.
  - On the first clk edge after reset deasserts: S_RESET -> FETCH.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after reset assertion.
- States and their outputs. Any output not listed is 0.
  - FETCH: Adrsrc=0, IRwrite=1, ALUsrcA=00, ALUsrcB=10, ALUop=add, Resultsrc=10, PCwrite=1. Next: DECODE.
  - DECODE: ALUsrcA=01, ALUsrcB=01, ALUop=add (branch/jump target into ALUout). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - otherwise -> TRAP
  - MEMADR: ALUsrcA=10, ALUsrcB=01, add. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: Adrsrc=1, Resultsrc=00. Next: MEMWB.
  - MEMWB: Resultsrc=01, Regwrite=1. Next: FETCH.
  - MEMWRITE: Adrsrc=1, Resultsrc=00, Memwrite=1. Next: FETCH.
  - EXECR: ALUsrcA=10, ALUsrcB=00, ALUop=funct. Next: ALUWB.
  - EXECI: ALUsrcA=10, ALUsrcB=01, ALUop=funct. Next: ALUWB.
  - ALUWB: Resultsrc=00, Regwrite=1. Next: FETCH.
  - BRANCH: ALUsrcA=10, ALUsrcB=00, sub, Resultsrc=00.
    - PCwrite = zero1 XOR funct3[0]: beq takes on zero, bne on nonzero.
    - funct3 other than 000/001 -> TRAP instead of FETCH, with PCwrite=0.
  - JAL: ALUsrcA=01, ALUsrcB=10, add, Resultsrc=00, PCwrite=1. Next: ALUWB (rd <= oldPC+4).
  - TRAP: all enables 0, illegal=1. Held until reset.
- Output timing:
  - PCwrite in BRANCH is combinational from zero1.
  - All other outputs are pure functions of state.
- immsrc is combinational from instr[6:0], independent of state:
  - load/OP-IMM -> 00
  - store -> 01
  - branch -> 10
  - jal -> 11
  - else 00
- ALU decode (ALUop=funct) on funct3:
  - 000: sub only if R-type and funct7[5]=1, else add
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7[5], else srl
  - 110: or
  - 111: and
- ALUcontrol encoding: add=0000, sub=0001, and=0010, or=0011, xor=0100, slt=0101, sll=0110, srl=0111, sra=1000, sltu=1001.
- Cycle counts: lw 5, sw 4, R 4, I 4, branch 3, jal 4.
- At most one of Memwrite/Regwrite/IRwrite is asserted in any state.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state enum (S_RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP; 4-bit)
  - opcode constants
  - ALUcontrol codes
  - ALUsrcA/ALUsrcB/Resultsrc/immsrc select codes
- One combinational sub-module, mc_alu_decoder, maps (ALUop[1:0], funct3, funct7[5], opcode[5]) to ALUcontrol.

Test Plan:
- Reset: assert reset mid-EXECR -> same cycle state_dbg=S_RESET and all outputs 0; release -> FETCH next edge, IRwrite=1, PCwrite=1, ALUsrcB=10.
- lw x2,0(x1) (0x0000A103) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; Regwrite=1 only in MEMWB with Resultsrc=01; immsrc=00.
- sw x2,4(x1) (0x0020A223) -> 4 cycles; Memwrite=1 only in MEMWRITE with Adrsrc=1; immsrc=01; Regwrite never set.
- add (0x002081B3) -> ALUcontrol=0000 in EXECR; sub (0x402081B3) -> 0001; addi x1,x0,5 (0x00500093) with funct7 bits clear -> 0000; srai -> 1000.
- beq x0,x0,8 (0x00000463):
  - with zero1=1 -> PCwrite=1 in BRANCH;
  - with zero1=0 -> PCwrite=0;
  - bne (funct3=001) inverts both;
  - next state FETCH after 3 cycles.
- jal x1,16 (0x010000EF) -> JAL PCwrite=1, ALUsrcA=01, ALUsrcB=10, then ALUWB Regwrite=1. Opcode 0x00000000 -> TRAP, illegal=1, no enables for 20 cycles until reset.
